issue_read_operands: RTL and testbench

// - Sits directly downstream of the scoreboard. Takes the issued instruction, resolves RS1/RS2 operands and registers the result for the functional units.
// - Operand sources: scoreboard result entries, write-back ports, or the architectural register file.
// - Tracks the youngest in-flight producer of each architectural register and stalls issue until every needed operand is available.

---
 rtl/issue_read_operands_pkg.sv | 53 +++++
 rtl/issue_read_operands_if.sv | 31 +++
 rtl/issue_read_operands_operand_resolve.sv | 62 ++++++
 rtl/issue_read_operands.sv | 106 ++++++++++
 tb/tb_issue_read_operands.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_read_operands_pkg.sv
// Shared types for the issue/read-operands stage.
// Sizes of the scoreboard, write-back ports and register file live here.
package issue_read_operands_pkg;

  localparam int NrArchRegs      = 32;
  localparam int ScoreboardDepth = 8;
  localparam int ScoreboardIndex = $clog2(ScoreboardDepth);
  localparam int WriteBackPorts  = 2;

  typedef logic [ScoreboardIndex-1:0] trans_id_t;

  typedef struct packed {
    trans_id_t   trans_id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_imm;
    logic        use_pc;
    logic [31:0] imm;
    logic [31:0] pc;
  } decoder_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
  } sb_fwd_t;

  typedef struct packed {
    logic        valid;
    trans_id_t   trans_id;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    sb_fwd_t [ScoreboardDepth-1:0] instr;
    wb_t     [WriteBackPorts-1:0]  wb;
  } forwarding_t;

  typedef struct packed {
    decoder_t    instr;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } fu_data_t;

  typedef struct packed {
    logic      busy;
    trans_id_t trans_id;
  } clobber_t;

endpackage

// File: rtl/issue_read_operands_if.sv
// Issue-side and functional-unit-side handshakes of the stage.
// master drives instructions in and takes results; slave is the stage.
interface issue_read_operands_if
  import issue_read_operands_pkg::*;
;
  decoder_t issue_instr;
  logic     issue_valid;
  logic     issue_ready;
  fu_data_t fu_data;
  logic     fu_valid;
  logic     fu_ready;

  modport master (
    output issue_instr,
    output issue_valid,
    input  issue_ready,
    input  fu_data,
    input  fu_valid,
    output fu_ready
  );

  modport slave (
    input  issue_instr,
    input  issue_valid,
    output issue_ready,
    output fu_data,
    output fu_valid,
    input  fu_ready
  );

endinterface

// File: rtl/issue_read_operands_operand_resolve.sv
// Resolves one source operand from RF, scoreboard or write-back.
// Purely combinational; one copy per source register.
module issue_read_operands_operand_resolve
  import issue_read_operands_pkg::*;
(
  input  logic        used,
  input  logic [4:0]  rs,
  input  clobber_t    clob,
  input  logic [31:0] rf_data,
  input  forwarding_t fwd,
  output logic [31:0] value,
  output logic        avail
);

  logic        skip;
  logic        sb_hit;
  logic        wb_hit;
  logic [31:0] wb_data;

  assign skip   = !used || (rs == 5'd0);
  assign sb_hit = fwd.instr[clob.trans_id].valid;

  // Walk downwards so the lowest matching port wins.
  always_comb begin
    wb_hit  = 1'b0;
    wb_data = '0;
    for (int i = WriteBackPorts - 1; i >= 0; i--) begin
      if (fwd.wb[i].valid &&
          fwd.wb[i].trans_id == clob.trans_id) begin
        wb_hit  = 1'b1;
        wb_data = fwd.wb[i].data;
      end
    end
  end

  always_comb begin
    value = '0;
    avail = 1'b0;
    unique case (1'b1)
      skip: begin
        avail = 1'b1;
      end
      !skip && !clob.busy: begin
        value = rf_data;
        avail = 1'b1;
      end
      !skip && clob.busy && sb_hit: begin
        value = fwd.instr[clob.trans_id].result;
        avail = 1'b1;
      end
      !skip && clob.busy && !sb_hit && wb_hit: begin
        value = wb_data;
        avail = 1'b1;
      end
      default: begin
        value = '0;
        avail = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/issue_read_operands.sv
// Operand read stage: clobber table, operand muxing, FU output register.
// Stalls issue until both sources are readable and the FU slot is free.
module issue_read_operands
  import issue_read_operands_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  issue_read_operands_if.slave  io,
  input  forwarding_t           fwd,
  output logic [1:0][4:0]       rf_raddr,
  input  logic [1:0][31:0]      rf_rdata,
  input  logic                  commit_valid,
  input  decoder_t              commit_instr
);

  clobber_t [NrArchRegs-1:0] clobber_q, clobber_d;
  fu_data_t                  fu_data_q, fu_data_d;
  logic                      fu_valid_q, fu_valid_d;

  decoder_t    in;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_ok, rs2_ok;
  logic        accept;
  logic        unused_commit;

  assign in            = io.issue_instr;
  assign rf_raddr      = {in.rs2, in.rs1};
  assign unused_commit = ^commit_instr;

  issue_read_operands_operand_resolve u_rs1 (
    .used    (in.use_rs1),
    .rs      (in.rs1),
    .clob    (clobber_q[in.rs1]),
    .rf_data (rf_rdata[0]),
    .fwd     (fwd),
    .value   (rs1_val),
    .avail   (rs1_ok)
  );

  issue_read_operands_operand_resolve u_rs2 (
    .used    (in.use_rs2),
    .rs      (in.rs2),
    .clob    (clobber_q[in.rs2]),
    .rf_data (rf_rdata[1]),
    .fwd     (fwd),
    .value   (rs2_val),
    .avail   (rs2_ok)
  );

  assign accept = io.issue_valid && rs1_ok && rs2_ok &&
                  (!fu_valid_q || io.fu_ready) &&
                  !flush && !reset;

  assign io.issue_ready = accept;
  assign io.fu_data     = fu_data_q;
  assign io.fu_valid    = fu_valid_q;

  always_comb begin
    fu_data_d  = fu_data_q;
    fu_valid_d = fu_valid_q;
    if (flush) begin
      fu_valid_d = 1'b0;
    end else if (accept) begin
      fu_valid_d      = 1'b1;
      fu_data_d.instr = in;
      fu_data_d.op_a  = in.use_pc  ? in.pc  : rs1_val;
      fu_data_d.op_b  = in.use_imm ? in.imm : rs2_val;
    end else if (io.fu_ready) begin
      fu_valid_d = 1'b0;
    end
  end

  // Commit clears only its own entry; a later issue to rd overrides it.
  always_comb begin
    clobber_d = clobber_q;
    if (commit_valid && commit_instr.rd_we &&
        clobber_q[commit_instr.rd].trans_id ==
        commit_instr.trans_id) begin
      clobber_d[commit_instr.rd].busy = 1'b0;
    end
    if (accept && in.rd_we && in.rd != 5'd0) begin
      clobber_d[in.rd].busy     = 1'b1;
      clobber_d[in.rd].trans_id = in.trans_id;
    end
    if (flush) begin
      for (int r = 0; r < NrArchRegs; r++) begin
        clobber_d[r].busy = 1'b0;
      end
    end
    clobber_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clobber_q  <= '0;
      fu_data_q  <= '0;
      fu_valid_q <= 1'b0;
    end else begin
      clobber_q  <= clobber_d;
      fu_data_q  <= fu_data_d;
      fu_valid_q <= fu_valid_d;
    end
  end

endmodule

// File: tb/tb_issue_read_operands.sv
// Random stimulus vs. an in-flight-list model; scoreboard queue for FU output.
// The model finds the youngest uncommitted writer of each source register.
module tb_issue_read_operands;
  import issue_read_operands_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  forwarding_t      fwd;
  logic [1:0][4:0]  rf_raddr;
  logic [1:0][31:0] rf_rdata;
  logic             commit_valid;
  decoder_t         commit_instr;

  issue_read_operands_if io ();

  issue_read_operands dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .io           (io),
    .fwd          (fwd),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .commit_valid (commit_valid),
    .commit_instr (commit_instr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [4:0] rd;
    logic       we;
  } fl_t;

  logic [31:0] rf [32];
  fl_t         infl [$];
  logic [31:0] res  [ScoreboardDepth];
  bit          done [ScoreboardDepth];
  fu_data_t    exp_q [$];
  bit          m_fu_valid;
  bit          holding;
  int          next_id;
  int          vectors;
  int          miscompares;
  bit          pend_we;
  logic [4:0]  pend_rd;
  logic [31:0] pend_val;

  always_comb begin
    rf_rdata[0] = rf[rf_raddr[0]];
    rf_rdata[1] = rf[rf_raddr[1]];
  end

  function automatic bit on_wb(input int t);
    for (int i = 0; i < WriteBackPorts; i++)
      if (fwd.wb[i].valid && int'(fwd.wb[i].trans_id) == t)
        return 1'b1;
    return 1'b0;
  endfunction

  // Youngest in-flight writer supplies the value once it is produced.
  function automatic void model_op(input logic used,
                                   input logic [4:0] rs,
                                   output bit ok,
                                   output logic [31:0] v);
    ok = 1'b1;
    v  = '0;
    if (!used || rs == 5'd0) return;
    for (int k = infl.size() - 1; k >= 0; k--) begin
      if (infl[k].we && infl[k].rd == rs) begin
        if (done[infl[k].id] || on_wb(infl[k].id))
          v = res[infl[k].id];
        else
          ok = 1'b0;
        return;
      end
    end
    v = rf[rs];
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic drive(input int cyc, input bit drain);
    decoder_t d;
    int k;
    for (int t = 0; t < ScoreboardDepth; t++) begin
      fwd.instr[t].valid  = 1'b0;
      fwd.instr[t].result = $urandom;
    end
    foreach (infl[j])
      if (done[infl[j].id]) begin
        fwd.instr[infl[j].id].valid  = 1'b1;
        fwd.instr[infl[j].id].result = res[infl[j].id];
      end
    for (int i = 0; i < WriteBackPorts; i++) begin
      fwd.wb[i].valid    = 1'b0;
      fwd.wb[i].trans_id = trans_id_t'($urandom);
      fwd.wb[i].data     = $urandom;
      if (infl.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, infl.size() - 1);
        fwd.wb[i].valid    = 1'b1;
        fwd.wb[i].trans_id = trans_id_t'(infl[k].id);
        fwd.wb[i].data     = res[infl[k].id];
      end
    end
    commit_instr          = '0;
    commit_instr.rd       = 5'($urandom);
    commit_instr.rd_we    = 1'($urandom);
    commit_instr.trans_id = trans_id_t'($urandom);
    commit_valid          = 1'b0;
    if (!drain && infl.size() > 0 && done[infl[0].id] &&
        $urandom_range(0, 1) == 1) begin
      commit_valid          = 1'b1;
      commit_instr.rd       = infl[0].rd;
      commit_instr.rd_we    = infl[0].we;
      commit_instr.trans_id = trans_id_t'(infl[0].id);
    end
    reset = !drain && (cyc == 700);
    flush = !drain && !reset && ($urandom_range(0, 39) == 0);
    if (!drain && !holding && infl.size() < ScoreboardDepth &&
        $urandom_range(0, 3) != 0) begin
      d          = '0;
      d.trans_id = trans_id_t'(next_id);
      d.rs1      = pick_reg();
      d.rs2      = pick_reg();
      d.rd       = pick_reg();
      d.rd_we    = ($urandom_range(0, 3) != 0);
      d.use_rs1  = ($urandom_range(0, 5) != 0);
      d.use_rs2  = ($urandom_range(0, 2) != 0);
      d.use_imm  = ($urandom_range(0, 2) == 0);
      d.use_pc   = ($urandom_range(0, 5) == 0);
      d.imm      = $urandom;
      d.pc       = $urandom;
      io.issue_instr = d;
      holding        = 1'b1;
    end
    io.issue_valid = holding;
    io.fu_ready    = drain || ($urandom_range(0, 3) != 0);
  endtask

  task automatic evaluate();
    bit          ok1, ok2, exp_rdy;
    logic [31:0] v1, v2;
    fu_data_t    e;
    decoder_t    d;
    d = io.issue_instr;
    model_op(d.use_rs1, d.rs1, ok1, v1);
    model_op(d.use_rs2, d.rs2, ok2, v2);
    exp_rdy = io.issue_valid && ok1 && ok2 &&
              (!m_fu_valid || io.fu_ready) && !flush && !reset;
    vectors++;
    if (io.issue_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL issue_ready t=%0t got %b want %b",
               $time, io.issue_ready, exp_rdy);
    end
    vectors++;
    if (io.fu_valid !== m_fu_valid) begin
      miscompares++;
      $display("FAIL fu_valid t=%0t got %b want %b",
               $time, io.fu_valid, m_fu_valid);
    end
    for (int i = 0; i < WriteBackPorts; i++)
      if (fwd.wb[i].valid) done[fwd.wb[i].trans_id] = 1'b1;
    pend_we = 1'b0;
    if (commit_valid) begin
      pend_we  = commit_instr.rd_we && commit_instr.rd != 5'd0;
      pend_rd  = commit_instr.rd;
      pend_val = res[commit_instr.trans_id];
      void'(infl.pop_front());
    end
    if (exp_rdy) begin
      e.instr = d;
      e.op_a  = d.use_pc  ? d.pc  : v1;
      e.op_b  = d.use_imm ? d.imm : v2;
      exp_q.push_back(e);
      res[d.trans_id]  = $urandom;
      done[d.trans_id] = 1'b0;
      infl.push_back('{id: int'(d.trans_id), rd: d.rd, we: d.rd_we});
      holding = 1'b0;
      next_id = (next_id + 1) % ScoreboardDepth;
    end
    if (reset || flush) begin
      infl.delete();
      m_fu_valid = 1'b0;
    end else if (exp_rdy) begin
      m_fu_valid = 1'b1;
    end else if (io.fu_ready) begin
      m_fu_valid = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (io.fu_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL fu_data t=%0t got %h with nothing expected",
                   $time, io.fu_data);
        end else if (io.fu_data !== exp_q[0]) begin
          miscompares++;
          $display("FAIL fu_data t=%0t got %h want %h",
                   $time, io.fu_data, exp_q[0]);
        end
        if ((io.fu_ready || flush || reset) && exp_q.size() > 0)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    holding     = 1'b0;
    next_id     = 0;
    m_fu_valid  = 1'b0;
    pend_we     = 1'b0;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    for (int t = 0; t < ScoreboardDepth; t++) begin
      res[t]  = '0;
      done[t] = 1'b0;
    end
    reset          = 1'b1;
    flush          = 1'b0;
    fwd            = '0;
    commit_valid   = 1'b0;
    commit_instr   = '0;
    io.issue_instr = '0;
    io.issue_valid = 1'b1;
    io.fu_ready    = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors += 3;
    if (io.issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_issue_ready got %b want 0", io.issue_ready);
    end
    if (io.fu_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fu_valid got %b want 0", io.fu_valid);
    end
    if (io.fu_data !== '0) begin
      miscompares++;
      $display("FAIL reset_fu_data got %h want 0", io.fu_data);
    end
    @(posedge clock);
    #1;
    reset          = 1'b0;
    io.issue_valid = 1'b0;
    for (int cyc = 0; cyc < 2010; cyc++) begin
      if (pend_we) rf[pend_rd] = pend_val;
      pend_we = 1'b0;
      drive(cyc, cyc >= 2000);
      @(negedge clock);
      evaluate();
      @(posedge clock);
      #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain %0d results never delivered, want 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
